// File: rtl/generic_1clk_fifo_env_if.sv
// Handshake/status bundle for generic_1clk_fifo_env.
// The master drives requests; the slave (the FIFO) drives data and status.
interface generic_1clk_fifo_env_if #(
  parameter int DAT_WIDTH = 35,
  parameter int PTR_WIDTH = 3
);
  logic                 flush;
  logic                 wr_op;
  logic [DAT_WIDTH-1:0] wr_data;
  logic [DAT_WIDTH-1:0] wr_mask;
  logic                 full;
  logic                 almost_full;
  logic                 rd_op;
  logic [DAT_WIDTH-1:0] rd_data;
  logic                 rd_valid;
  logic                 empty;
  logic                 almost_empty;
  logic [PTR_WIDTH:0]   entry_used;
  logic                 full_err;
  logic                 empty_err;
  logic                 err_clr;

  modport master (
    output flush, wr_op, wr_data, wr_mask, rd_op, err_clr,
    input  full, almost_full, rd_data, rd_valid, empty, almost_empty,
           entry_used, full_err, empty_err
  );

  modport slave (
    input  flush, wr_op, wr_data, wr_mask, rd_op, err_clr,
    output full, almost_full, rd_data, rd_valid, empty, almost_empty,
           entry_used, full_err, empty_err
  );
endinterface

// File: rtl/generic_1clk_fifo_env.sv
// Single-clock flop-based FIFO with write masking, sticky error flags, flush
// and a selectable first-word-fall-through or registered read port.
module generic_1clk_fifo_env #(
  parameter int PTR_WIDTH      = 3,
  parameter int NUM_OF_ENTRIES = 8,
  parameter int DAT_WIDTH      = 35,
  parameter int AF_LEVEL       = 6,
  parameter int AE_LEVEL       = 1,
  parameter int FWFT           = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  generic_1clk_fifo_env_if.slave  bus
);

  localparam logic [PTR_WIDTH:0]   CNT_MAX  = (PTR_WIDTH+1)'(NUM_OF_ENTRIES);
  localparam logic [PTR_WIDTH:0]   AF_CNT   = (PTR_WIDTH+1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0]   AE_CNT   = (PTR_WIDTH+1)'(AE_LEVEL);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(NUM_OF_ENTRIES - 1);

  logic [DAT_WIDTH-1:0] mem [NUM_OF_ENTRIES];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH:0]   count;
  logic                 full_err_q;
  logic                 empty_err_q;

  logic is_full;
  logic is_empty;
  logic rd_accept;
  logic wr_accept;
  logic full_set;
  logic empty_set;

  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  endfunction

  assign is_full  = (count == CNT_MAX);
  assign is_empty = (count == '0);

  // Flush swallows any same-cycle request, so nothing is accepted or flagged.
  always_comb begin
    rd_accept = bus.rd_op && !is_empty && !bus.flush;
    wr_accept = bus.wr_op && (!is_full || rd_accept) && !bus.flush;
    full_set  = bus.wr_op && is_full && !rd_accept && !bus.flush;
    empty_set = bus.rd_op && is_empty && !bus.flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) wr_ptr <= next_ptr(wr_ptr);
      if (rd_accept) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= bus.wr_data & bus.wr_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_err_q  <= 1'b0;
      empty_err_q <= 1'b0;
    end else begin
      full_err_q  <= full_set  | (full_err_q  & ~bus.err_clr);
      empty_err_q <= empty_set | (empty_err_q & ~bus.err_clr);
    end
  end

  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (count >= AF_CNT);
  assign bus.almost_empty = (count <= AE_CNT);
  assign bus.entry_used   = count;
  assign bus.full_err     = full_err_q;
  assign bus.empty_err    = empty_err_q;

  if (FWFT != 0) begin : g_fwft
    assign bus.rd_data  = is_empty ? '0 : mem[rd_ptr];
    assign bus.rd_valid = !is_empty;
  end else begin : g_reg_read
    logic [DAT_WIDTH-1:0] rd_data_q;
    logic                 rd_valid_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (bus.flush) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_accept;
        if (rd_accept) rd_data_q <= mem[rd_ptr];
      end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_generic_1clk_fifo_env.sv
// Scoreboard bench: a 5-deep FWFT FIFO (a) and a 5-deep registered-read FIFO (b)
// driven by directed vectors; monitors pop expected read data on each presented word.
module tb_generic_1clk_fifo_env;

  localparam int DW = 35;
  localparam int PW = 3;
  localparam logic [DW-1:0] ALL = '1;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_b[$];

  generic_1clk_fifo_env_if #(.DAT_WIDTH(DW), .PTR_WIDTH(PW)) a_bus();
  generic_1clk_fifo_env_if #(.DAT_WIDTH(DW), .PTR_WIDTH(PW)) b_bus();

  generic_1clk_fifo_env #(
    .PTR_WIDTH(PW), .NUM_OF_ENTRIES(5), .DAT_WIDTH(DW),
    .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(a_bus)
  );

  generic_1clk_fifo_env #(
    .PTR_WIDTH(PW), .NUM_OF_ENTRIES(5), .DAT_WIDTH(DW),
    .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(b_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic idle_all();
    a_bus.flush = 0; a_bus.wr_op = 0; a_bus.wr_data = '0; a_bus.wr_mask = '0;
    a_bus.rd_op = 0; a_bus.err_clr = 0;
    b_bus.flush = 0; b_bus.wr_op = 0; b_bus.wr_data = '0; b_bus.wr_mask = '0;
    b_bus.rd_op = 0; b_bus.err_clr = 0;
  endtask

  // One clock of stimulus on fifo a; push queues the word a read must later return.
  task automatic apply_stimulus(input logic fl, input logic wr, input logic [DW-1:0] d,
                                input logic [DW-1:0] m, input logic rd, input logic ec,
                                input logic push, input logic [DW-1:0] exp);
    if (push) exp_a.push_back(exp);
    a_bus.flush = fl; a_bus.wr_op = wr; a_bus.wr_data = d; a_bus.wr_mask = m;
    a_bus.rd_op = rd; a_bus.err_clr = ec;
    @(posedge clk);
    #1;
    idle_all();
  endtask

  task automatic apply_stimulus_b(input logic wr, input logic [DW-1:0] d, input logic rd,
                                  input logic ec, input logic push, input logic [DW-1:0] exp);
    if (push) exp_b.push_back(exp);
    b_bus.wr_op = wr; b_bus.wr_data = d; b_bus.wr_mask = ALL;
    b_bus.rd_op = rd; b_bus.err_clr = ec;
    @(posedge clk);
    #1;
    idle_all();
  endtask

  task automatic write_a(input logic [DW-1:0] d, input logic push);
    apply_stimulus(0, 1, d, ALL, 0, 0, push, d);
  endtask

  task automatic read_a();
    apply_stimulus(0, 0, '0, '0, 1, 0, 0, '0);
  endtask

  task automatic clear_a();
    apply_stimulus(0, 0, '0, '0, 0, 1, 0, '0);
  endtask

  always @(negedge clk) begin
    if (!reset && a_bus.rd_op && a_bus.rd_valid && !a_bus.flush) begin
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL a_unexpected_read: got 0x%0h expected no data", a_bus.rd_data);
      end else begin
        check_output("a_rd_data", 64'(a_bus.rd_data), 64'(exp_a.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && b_bus.rd_valid) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL b_unexpected_valid: got 0x%0h expected no data", b_bus.rd_data);
      end else begin
        check_output("b_rd_data", 64'(b_bus.rd_data), 64'(exp_b.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    idle_all();
    #1 reset = 1'b1;
    #2;
    check_output("rst_empty", 64'(a_bus.empty), 64'd1);
    check_output("rst_almost_empty", 64'(a_bus.almost_empty), 64'd1);
    check_output("rst_full", 64'(a_bus.full), 64'd0);
    check_output("rst_almost_full", 64'(a_bus.almost_full), 64'd0);
    check_output("rst_entry_used", 64'(a_bus.entry_used), 64'd0);
    check_output("rst_rd_valid", 64'(a_bus.rd_valid), 64'd0);
    check_output("rst_rd_data", 64'(a_bus.rd_data), 64'd0);
    check_output("rst_errs", 64'({a_bus.full_err, a_bus.empty_err}), 64'd0);
    check_output("rst_b_rd_data", 64'(b_bus.rd_data), 64'd0);
    check_output("rst_b_rd_valid", 64'(b_bus.rd_valid), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // Fill 1..5, sixth write is dropped and flags full_err.
    for (int i = 1; i <= 5; i++) begin
      write_a(DW'(i), 1'b1);
      check_output("fill_entry_used", 64'(a_bus.entry_used), 64'(i));
      check_output("fill_full", 64'(a_bus.full), 64'(i == 5));
      check_output("fill_almost_full", 64'(a_bus.almost_full), 64'(i >= 4));
      check_output("fill_almost_empty", 64'(a_bus.almost_empty), 64'(i <= 1));
    end
    write_a(DW'(6), 1'b0);
    check_output("overflow_full_err", 64'(a_bus.full_err), 64'd1);
    check_output("overflow_entry_used", 64'(a_bus.entry_used), 64'd5);
    clear_a();
    check_output("full_err_cleared", 64'(a_bus.full_err), 64'd0);

    apply_stimulus(0, 1, 35'h77, ALL, 1, 0, 1, 35'h77);
    check_output("simul_entry_used", 64'(a_bus.entry_used), 64'd5);
    check_output("simul_no_full_err", 64'(a_bus.full_err), 64'd0);

    for (int i = 0; i < 5; i++) read_a();
    check_output("drain_empty", 64'(a_bus.empty), 64'd1);
    check_output("drain_entry_used", 64'(a_bus.entry_used), 64'd0);

    read_a();
    check_output("underflow_empty_err", 64'(a_bus.empty_err), 64'd1);
    apply_stimulus(0, 0, '0, '0, 1, 1, 0, '0);
    check_output("set_beats_clear", 64'(a_bus.empty_err), 64'd1);
    clear_a();
    check_output("empty_err_cleared", 64'(a_bus.empty_err), 64'd0);

    // A write into an empty FIFO is never bypassed to a same-cycle read.
    apply_stimulus(0, 1, 35'h9, ALL, 1, 0, 1, 35'h9);
    check_output("nobypass_empty_err", 64'(a_bus.empty_err), 64'd1);
    check_output("nobypass_entry_used", 64'(a_bus.entry_used), 64'd1);
    clear_a();
    read_a();

    for (int i = 0; i < 20; i++) begin
      write_a(DW'(32'h100 + i), 1'b1);
      check_output("wrap_used_after_wr", 64'(a_bus.entry_used), 64'd1);
      read_a();
      check_output("wrap_used_after_rd", 64'(a_bus.entry_used), 64'd0);
    end

    apply_stimulus(0, 1, 35'h7_FFFF_FFFF, 35'h0_0000_00FF, 0, 0, 1, 35'h0_0000_00FF);
    read_a();

    for (int i = 0; i < 3; i++) write_a(DW'(32'h200 + i), 1'b0);
    check_output("preflush_used", 64'(a_bus.entry_used), 64'd3);
    apply_stimulus(1, 1, 35'h3F, ALL, 0, 0, 0, '0);
    check_output("flush_entry_used", 64'(a_bus.entry_used), 64'd0);
    check_output("flush_empty", 64'(a_bus.empty), 64'd1);
    check_output("flush_rd_valid", 64'(a_bus.rd_valid), 64'd0);
    check_output("flush_errs", 64'({a_bus.full_err, a_bus.empty_err}), 64'd0);
    write_a(35'h55, 1'b1);
    read_a();

    read_a();
    check_output("pre_reset_empty_err", 64'(a_bus.empty_err), 64'd1);
    write_a(35'h1, 1'b0);
    write_a(35'h2, 1'b0);
    a_bus.wr_op = 1; a_bus.wr_data = 35'h3; a_bus.wr_mask = ALL;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_output("midrst_entry_used", 64'(a_bus.entry_used), 64'd0);
    check_output("midrst_empty", 64'(a_bus.empty), 64'd1);
    check_output("midrst_almost_empty", 64'(a_bus.almost_empty), 64'd1);
    check_output("midrst_full_flags", 64'({a_bus.full, a_bus.almost_full}), 64'd0);
    check_output("midrst_rd", 64'({a_bus.rd_valid, a_bus.rd_data}), 64'd0);
    check_output("midrst_errs", 64'({a_bus.full_err, a_bus.empty_err}), 64'd0);
    idle_all();
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // Registered read port.
    apply_stimulus_b(1, 35'hA, 0, 0, 0, '0);
    check_output("b_no_valid_before_read", 64'(b_bus.rd_valid), 64'd0);
    apply_stimulus_b(0, '0, 1, 0, 1, 35'hA);
    check_output("b_valid_after_read", 64'(b_bus.rd_valid), 64'd1);
    check_output("b_data_after_read", 64'(b_bus.rd_data), 64'hA);
    apply_stimulus_b(0, '0, 0, 0, 0, '0);
    check_output("b_valid_one_cycle", 64'(b_bus.rd_valid), 64'd0);
    check_output("b_data_held", 64'(b_bus.rd_data), 64'hA);
    apply_stimulus_b(0, '0, 1, 0, 0, '0);
    check_output("b_empty_err", 64'(b_bus.empty_err), 64'd1);
    check_output("b_no_valid_on_empty", 64'(b_bus.rd_valid), 64'd0);
    apply_stimulus_b(0, '0, 0, 1, 0, '0);
    check_output("b_empty_err_cleared", 64'(b_bus.empty_err), 64'd0);

    @(posedge clk); #1;
    check_output("a_queue_drained", 64'(exp_a.size()), 64'd0);
    check_output("b_queue_drained", 64'(exp_b.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/generic_1clk_fifo_env.md
GENERIC_1CLK_FIFO_ENV -- requirements
Module: generic_1clk_fifo_env

Interface
REQ-001 SHALL have parameter PTR_WIDTH, 3, address width; 2^PTR_WIDTH >= NUM_OF_ENTRIES.
REQ-002 SHALL have parameter NUM_OF_ENTRIES, 8, depth; any value 2..2^PTR_WIDTH, non-power-of-2 legal.
REQ-003 SHALL have parameter DAT_WIDTH, 35, data width.
REQ-004 SHALL have parameter AF_LEVEL, 6, almost_full threshold (count >= AF_LEVEL).
REQ-005 SHALL have parameter AE_LEVEL, 1, almost_empty threshold (count <= AE_LEVEL).
REQ-006 SHALL have parameter FWFT, 1, read mode: 1 = first-word-fall-through, 0 = registered read.
REQ-007 SHALL have ports, listed as name, direction, width, meaning:
 clk  in  1  single clock; all logic rising-edge.
 reset  in  1  asynchronous, active-high reset.
 flush  in  1  synchronous empty request.
 wr_op  in  1  write request.
 wr_data  in  DAT_WIDTH  write data.
 wr_mask  in  DAT_WIDTH  per-bit write enable; 0 bits stored as 0.
 full  out  1  count == NUM_OF_ENTRIES.
 almost_full  out  1  count >= AF_LEVEL.
 rd_op  in  1  read request / pop.
 rd_data  out  DAT_WIDTH  read data.
 rd_valid  out  1  rd_data qualifier.
 empty  out  1  count == 0.
 almost_empty  out  1  count <= AE_LEVEL.
 entry_used  out  PTR_WIDTH+1  current occupancy.
 full_err  out  1  sticky: write attempted while full.
 empty_err  out  1  sticky: read attempted while empty.
 err_clr  in  1  clears both sticky error flags.

Function
REQ-008 SHALL store NUM_OF_ENTRIES words in internal flop storage; stored word = wr_data AND wr_mask.
REQ-009 SHALL accept a read when rd_op=1 and empty=0.
REQ-010 SHALL accept a write when wr_op=1 and (full=0 or a read is accepted the same cycle).
REQ-011 SHALL advance write/read pointers by 1 per accepted op, wrapping NUM_OF_ENTRIES-1 -> 0.
REQ-012 SHALL update count by +1 (write only), -1 (read only), 0 (both or neither); flags registered, valid the cycle after the edge.
REQ-013 SHALL drive full, empty, almost_full, almost_empty, entry_used from the registered count only.
REQ-014 SHALL not bypass: write into empty FIFO with simultaneous rd_op -> read rejected, empty_err set, write accepted.
REQ-015 SHALL set full_err on rd-less wr_op while full; data dropped, pointers/count unchanged.
REQ-016 SHALL set empty_err on rd_op while empty; pointers/count unchanged.
REQ-017 SHALL clear full_err/empty_err on err_clr=1; a same-cycle set condition wins over err_clr.
REQ-018 SHALL on flush=1 zero pointers, count and rd_valid next edge, ignoring same-cycle wr_op/rd_op (no error flag set); storage and error flags untouched.
REQ-019 FWFT=1: rd_data = head word combinationally, 0 when empty; rd_valid = NOT empty.
REQ-020 FWFT=0: rd_data registered with head word on accepted read, held otherwise; rd_valid high exactly one cycle after each accepted read.

Reset
REQ-021 SHALL on reset=1 asynchronously clear pointers, count, rd_data, rd_valid, full, almost_full, full_err, empty_err; set empty=1, almost_empty=1 (AE_LEVEL >= 0).
REQ-022 SHALL not reset storage contents; reset mid-operation discards in-flight data, no error flagged.

Verification
REQ-023 Fill: N=5,PTR=3; 6 writes 0x1..0x6, mask all-ones -> full=1 after 5th, full_err=1 after 6th, entry_used=5; drain reads 0x1..0x5, 0x6 absent.
REQ-024 Wrap: N=5; 20 interleaved single writes/reads -> data order preserved across pointer wrap 4->0, entry_used never >1.
REQ-025 Simultaneous at full: N=5 full, wr_op+rd_op same cycle -> head popped, new word stored, entry_used stays 5, no full_err.
REQ-026 Mask: wr_data=0x7_FFFF_FFFF, wr_mask=0x0_0000_00FF -> read returns 0x0_0000_00FF.
REQ-027 FWFT=0: write 0xA, rd_op next cycle -> rd_valid and rd_data=0xA one cycle later; rd_op on empty -> empty_err=1, cleared by err_clr.
REQ-028 Flush/reset: 3 entries, flush with wr_op -> entry_used=0, empty=1, no error; assert reset mid-burst -> all outputs at REQ-021 values immediately.
